// File: rtl/gmii_rx_frame.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC-32, and streams
// payload bytes with sop/eop/err markers plus saturating good/bad frame counters.
module gmii_rx_frame #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             clk_125m,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_err,
  output logic [10:0]      rx_len,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  // Output stream: out_valid qualifies out_data (and sop/eop/err) for exactly one
  // cycle per byte. There is no ready; the consumer must take every byte offered.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [10:0]      GIANT_LEN = 11'(MAX_FRAME + 1);
  localparam logic [10:0]      MIN_LEN   = 11'(MIN_FRAME);
  localparam logic [10:0]      FIRST_OUT = 11'd5;
  localparam logic [31:0]      RESIDUE   = 32'hC704DD7B;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  state_t          state, state_n;
  logic            armed, armed_n;
  logic [31:0]     crc, crc_n;
  logic [10:0]     len, len_n;
  logic            sticky, sticky_n;
  logic [4:0][7:0] sr, sr_n;
  logic [7:0]      data_n;
  logic            valid_n, sop_n, eop_n, err_n;
  logic [10:0]     rx_len_n;
  logic            frame_inc, err_inc;

  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    armed_n   = armed;
    crc_n     = crc;
    len_n     = len;
    sticky_n  = sticky;
    sr_n      = sr;
    data_n    = out_data;
    valid_n   = 1'b0;
    sop_n     = 1'b0;
    eop_n     = 1'b0;
    err_n     = 1'b0;
    rx_len_n  = rx_len;
    frame_inc = 1'b0;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        // Only lock on after a gap has been seen, so a partial frame is never taken.
        if (!rx_dv)                       armed_n = 1'b1;
        else if (armed && rxd == 8'h55)   state_n = PREAMBLE;
        else                              armed_n = 1'b0;
      end
      PREAMBLE: begin
        if (!rx_dv || rx_er) begin
          state_n = DROP;
        end else if (rxd == 8'hD5) begin
          state_n  = DATA;
          crc_n    = '1;
          len_n    = '0;
          sticky_n = 1'b0;
        end else if (rxd != 8'h55) begin
          state_n = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          sr_n  = {sr[3:0], rxd};
          crc_n = crc_byte(crc, rxd);
          len_n = len + 11'd1;
          if (rx_er) sticky_n = 1'b1;
          // The byte leaving the delay line is payload once four bytes sit behind it.
          if (len >= FIRST_OUT) begin
            valid_n = 1'b1;
            data_n  = sr[4];
            sop_n   = (len == FIRST_OUT);
          end
          if (len_n == GIANT_LEN) begin
            eop_n    = 1'b1;
            err_n    = 1'b1;
            rx_len_n = len_n;
            err_inc  = 1'b1;
            state_n  = DROP;
          end
        end else begin
          state_n = IDLE;
          armed_n = 1'b1;
          crc_n   = '1;
          if (len >= FIRST_OUT) begin
            valid_n  = 1'b1;
            data_n   = sr[4];
            sop_n    = (len == FIRST_OUT);
            eop_n    = 1'b1;
            err_n    = (bit_rev(crc) != RESIDUE) || sticky || (len < MIN_LEN);
            rx_len_n = len;
            if (err_n) err_inc   = 1'b1;
            else       frame_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          state_n = IDLE;
          armed_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      crc       <= '1;
      len       <= '0;
      sticky    <= 1'b0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      rx_len    <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      armed     <= armed_n;
      crc       <= crc_n;
      len       <= len_n;
      sticky    <= sticky_n;
      sr        <= sr_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_sop   <= sop_n;
      out_eop   <= eop_n;
      out_err   <= err_n;
      rx_len    <= rx_len_n;
      if (frame_inc && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_ONE;
      if (err_inc && err_cnt != '1)     err_cnt   <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: directed frame vectors from a table, hand-written corner
// sequences, and a byte scoreboard on the output stream.
`timescale 1ns/1ps
module tb_gmii_rx_frame;
  localparam int W = 11;

  logic        clk_125m = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic [10:0] rx_len;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frm[$];
  logic [W-1:0] mon_e;

  typedef struct {
    int          n_pay;
    logic [7:0]  start;
    logic [7:0]  fcs_xor;
    int          er_idx;
    int          emit_n;
    logic        exp_err;
    logic [10:0] exp_len;
    logic [15:0] exp_fc;
    logic [15:0] exp_ec;
  } vec_t;

  gmii_rx_frame #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(16)) dut (
    .clk_125m (clk_125m),
    .rst      (rst),
    .rxd      (rxd),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_err  (out_err),
    .rx_len   (rx_len),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #4 clk_125m = ~clk_125m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic r);
    @(negedge clk_125m);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
    rst   = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // rst_pos and er_idx count bytes after the SFD; rst_pos == frame length hits the first idle.
  task automatic send_frame(input int n_pay, input logic [7:0] start, input logic [7:0] fcs_xor,
                            input int er_idx, input int rst_pos, input int ifg,
                            input int emit_n, input logic last_eop, input logic last_err);
    logic [31:0] c;
    int total;
    frm.delete();
    for (int i = 0; i < n_pay; i++) frm.push_back(8'(start + i));
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_step(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24] ^ fcs_xor);
    for (int i = 0; i < emit_n; i++)
      exp_q.push_back({(i == 0), last_eop && (i == emit_n - 1), last_err && (i == emit_n - 1), frm[i]});
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b0);
    total = frm.size();
    for (int p = 0; p < total + ifg; p++) begin
      if (p < total) drive(1'b1, (p == er_idx), frm[p], (p == rst_pos));
      else           drive(1'b0, 1'b0, 8'h00, (p == rst_pos));
    end
  endtask

  // scoreboard
  always @(negedge clk_125m) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got data 0x%0h sop %0b eop %0b err %0b, expected no output",
                 out_data, out_sop, out_eop, out_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_byte", {21'd0, out_sop, out_eop, out_err, out_data}, {21'd0, mon_e});
      end
    end
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{60,   8'h00, 8'h00, -1, 60,   1'b0, 11'd64,   16'd1, 16'd0};
    vecs[1] = '{60,   8'h00, 8'h01, -1, 60,   1'b1, 11'd64,   16'd1, 16'd1};
    vecs[2] = '{40,   8'h80, 8'h00, -1, 40,   1'b1, 11'd44,   16'd1, 16'd2};
    vecs[3] = '{60,   8'h10, 8'h00, 10, 60,   1'b1, 11'd64,   16'd1, 16'd3};
    vecs[4] = '{0,    8'h00, 8'h00, -1, 0,    1'b0, 11'd64,   16'd1, 16'd4};
    vecs[5] = '{1,    8'hC3, 8'h00, -1, 1,    1'b1, 11'd5,    16'd1, 16'd5};
    vecs[6] = '{59,   8'h00, 8'h00, -1, 59,   1'b1, 11'd63,   16'd1, 16'd6};
    vecs[7] = '{1514, 8'h20, 8'h00, -1, 1514, 1'b0, 11'd1518, 16'd2, 16'd6};
    vecs[8] = '{60,   8'hA5, 8'h00, -1, 60,   1'b0, 11'd64,   16'd3, 16'd6};

    rst   = 1'b1;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 8'h00;
    repeat (3) @(negedge clk_125m);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop",   out_sop, 0);
    check("rst_out_eop",   out_eop, 0);
    check("rst_out_err",   out_err, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_rx_len",    rx_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt",   err_cnt, 0);
    check("rst_state",     dbg_state, 0);
    idle(3);

    foreach (vecs[v]) begin
      send_frame(vecs[v].n_pay, vecs[v].start, vecs[v].fcs_xor, vecs[v].er_idx, -1, 3,
                 vecs[v].emit_n, (vecs[v].emit_n > 0), vecs[v].exp_err);
      idle(2);
      check($sformatf("v%0d_drain", v),     exp_q.size(), 0);
      check($sformatf("v%0d_rx_len", v),    rx_len, vecs[v].exp_len);
      check($sformatf("v%0d_frame_cnt", v), frame_cnt, vecs[v].exp_fc);
      check($sformatf("v%0d_err_cnt", v),   err_cnt, vecs[v].exp_ec);
    end

    // Giant: 1600 bytes after SFD, cut at length 1519 with the 1514th byte as eop.
    send_frame(1596, 8'h00, 8'h00, -1, -1, 3, 1514, 1'b1, 1'b1);
    idle(2);
    check("giant_drain",     exp_q.size(), 0);
    check("giant_rx_len",    rx_len, 1519);
    check("giant_frame_cnt", frame_cnt, 3);
    check("giant_err_cnt",   err_cnt, 7);
    check("giant_state",     dbg_state, 0);

    // Back-to-back with one idle cycle, then an aborted preamble.
    send_frame(60, 8'h30, 8'h00, -1, -1, 1, 60, 1'b1, 1'b0);
    send_frame(60, 8'h70, 8'h00, -1, -1, 1, 60, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    @(negedge clk_125m);
    check("bad_pre_state", dbg_state, 3);
    idle(4);
    check("b2b_drain",     exp_q.size(), 0);
    check("b2b_frame_cnt", frame_cnt, 5);
    check("b2b_err_cnt",   err_cnt, 7);
    check("b2b_state",     dbg_state, 0);

    // Reset on the end-of-frame cycle: last byte never appears, counters cleared.
    send_frame(60, 8'h00, 8'h00, -1, 64, 3, 59, 1'b0, 1'b0);
    idle(2);
    check("rst_eop_drain",     exp_q.size(), 0);
    check("rst_eop_frame_cnt", frame_cnt, 0);
    check("rst_eop_err_cnt",   err_cnt, 0);
    check("rst_eop_rx_len",    rx_len, 0);

    // Reset at payload byte 20, then a clean frame after 12 idles.
    send_frame(60, 8'h00, 8'h00, -1, 20, 12, 15, 1'b0, 1'b0);
    check("rst_mid_drain",     exp_q.size(), 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_err_cnt",   err_cnt, 0);
    check("rst_mid_state",     dbg_state, 0);
    send_frame(60, 8'h50, 8'h00, -1, -1, 3, 60, 1'b1, 1'b0);
    idle(2);
    check("after_rst_drain",     exp_q.size(), 0);
    check("after_rst_frame_cnt", frame_cnt, 1);
    check("after_rst_err_cnt",   err_cnt, 0);
    check("after_rst_rx_len",    rx_len, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
